// File: rtl/cv32e40p_pkg.sv
// Shared types and default constants for the TMR fault monitor.
// Optional build macro used by the monitor: CV32E40P_TMR_PERSIST_EN.
package cv32e40p_pkg;

  // Monitor FSM: no alarm, alarm pending acknowledge, persistent fault lock.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALARM  = 2'd1,
    LOCKED = 2'd2
  } tmr_mon_state_e;

  localparam int unsigned TMR_N_SRC_DEF      = 3;
  localparam int unsigned TMR_CNT_W_DEF      = 8;
  localparam int unsigned TMR_PERSIST_TH_DEF = 4;

  // Run counters never need more than 4 bits (threshold capped at 15).
  localparam int unsigned TMR_RUN_W = 4;

endpackage

// File: rtl/cv32e40p_tmr_persist_cnt.sv
// Per-source consecutive-fault run counter.
// Counts sampled faults on one voter source, resets on a clean sample,
// holds when not sampled and saturates at TH.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear_i     synchronous clear of the run count
//   sample_i    qualifier for fault_i
//   fault_i     faulty flag of this source
//   reach_c     combinational: this cycle's sample brings the count to TH
module cv32e40p_tmr_persist_cnt
  import cv32e40p_pkg::*;
#(
  parameter int unsigned TH = TMR_PERSIST_TH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic sample_i,
  input  logic fault_i,
  output logic reach_c
);

  logic [TMR_RUN_W-1:0] r_cnt;
  logic [TMR_RUN_W-1:0] w_cnt_nxt;

  // Next run count; clear has priority over sampling.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear_i) begin
      w_cnt_nxt = '0;
    end else if (sample_i) begin
      if (!fault_i) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != TMR_RUN_W'(TH)) begin
        w_cnt_nxt = r_cnt + TMR_RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Early indication so the lock lands on the same edge the count hits TH.
  assign reach_c = !clear_i && sample_i && fault_i && (r_cnt >= TMR_RUN_W'(TH - 1));

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// TMR voter fault monitor: counts fault events, raises an acknowledgeable
// alarm with a syndrome of faulty sources and, when built with
// CV32E40P_TMR_PERSIST_EN, locks on persistent per-source faults.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   sample_i        qualifies fault_i
//   fault_i         voter faulty flags, one bit per source
//   irq_ack_i       software acknowledge of the alarm
//   clear_i         synchronous full clear
//   irq_o           alarm request (state != IDLE)
//   syndrome_o      sources faulty in the current/last episode
//   total_cnt_o     saturating count of fault-event cycles
//   persist_o       persistent fault declared
//   persist_src_o   sticky per-source persistent flags
module cv32e40p_tmr_fault_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned N_SRC      = TMR_N_SRC_DEF,
  parameter int unsigned CNT_W      = TMR_CNT_W_DEF,
  parameter int unsigned PERSIST_TH = TMR_PERSIST_TH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
  input  logic [N_SRC-1:0] fault_i,
  input  logic             irq_ack_i,
  input  logic             clear_i,
  output logic             irq_o,
  output logic [N_SRC-1:0] syndrome_o,
  output logic [CNT_W-1:0] total_cnt_o,
  output logic             persist_o,
  output logic [N_SRC-1:0] persist_src_o
);

  if (PERSIST_TH < 1 || PERSIST_TH > 15) begin : g_bad_th
    $error("PERSIST_TH must be in 1..15");
  end

  tmr_mon_state_e   r_state;
  tmr_mon_state_e   w_state_nxt;
  logic             r_irq;
  logic [N_SRC-1:0] r_syn;
  logic [N_SRC-1:0] w_syn_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_event;
  logic             w_lock;

  assign w_event = sample_i && (|fault_i);

`ifdef CV32E40P_TMR_PERSIST_EN
  logic [N_SRC-1:0] w_reach;
  logic [N_SRC-1:0] r_persist_src;
  logic             r_persist;

  for (genvar k = 0; k < N_SRC; k++) begin : g_run
    cv32e40p_tmr_persist_cnt #(
      .TH (PERSIST_TH)
    ) u_run_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (clear_i),
      .sample_i (sample_i),
      .fault_i  (fault_i[k]),
      .reach_c  (w_reach[k])
    );
  end

  assign w_lock = |w_reach;

  // Sticky persistent flags, only removed by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_persist_src <= '0;
      r_persist     <= 1'b0;
    end else if (clear_i) begin
      r_persist_src <= '0;
      r_persist     <= 1'b0;
    end else begin
      r_persist_src <= r_persist_src | w_reach;
      r_persist     <= |(r_persist_src | w_reach);
    end
  end

  assign persist_o     = r_persist;
  assign persist_src_o = r_persist_src;
`else
  assign w_lock        = 1'b0;
  assign persist_o     = 1'b0;
  assign persist_src_o = '0;
`endif

  // Next state and syndrome; a new episode overwrites, an ongoing one accumulates.
  always_comb begin
    w_state_nxt = r_state;
    w_syn_nxt   = r_syn;
    if (clear_i) begin
      w_state_nxt = IDLE;
      w_syn_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_event) begin
            w_state_nxt = ALARM;
            w_syn_nxt   = fault_i;
          end
        end
        ALARM: begin
          if (irq_ack_i) begin
            if (w_event) begin
              w_syn_nxt = fault_i;
            end else begin
              w_state_nxt = IDLE;
            end
          end else if (w_event) begin
            w_syn_nxt = r_syn | fault_i;
          end
        end
        LOCKED: begin
          if (w_event) begin
            w_syn_nxt = r_syn | fault_i;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
      if (w_lock) begin
        w_state_nxt = LOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_syn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= (w_state_nxt != IDLE);
      r_syn   <= w_syn_nxt;
    end
  end

  // Saturating event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (w_event && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign irq_o       = r_irq;
  assign syndrome_o  = r_syn;
  assign total_cnt_o = r_cnt;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Directed bench for cv32e40p_tmr_fault_monitor (N_SRC=3, CNT_W=8, TH=4).
// Works in both builds; persistent-fault expectations follow
// CV32E40P_TMR_PERSIST_EN.
module tb_cv32e40p_tmr_fault_monitor;

`ifdef CV32E40P_TMR_PERSIST_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sample_i;
  logic [2:0] fault_i;
  logic       irq_ack_i;
  logic       clear_i;
  logic       irq_o;
  logic [2:0] syndrome_o;
  logic [7:0] total_cnt_o;
  logic       persist_o;
  logic [2:0] persist_src_o;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       s;
    logic [2:0] f;
    logic       ack;
    logic       clr;
    logic       irq;
    logic [2:0] syn;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [10];

  cv32e40p_tmr_fault_monitor #(
    .N_SRC      (3),
    .CNT_W      (8),
    .PERSIST_TH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_i      (sample_i),
    .fault_i       (fault_i),
    .irq_ack_i     (irq_ack_i),
    .clear_i       (clear_i),
    .irq_o         (irq_o),
    .syndrome_o    (syndrome_o),
    .total_cnt_o   (total_cnt_o),
    .persist_o     (persist_o),
    .persist_src_o (persist_src_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic s, input logic [2:0] f, input logic ack, input logic clr);
    @(negedge clk);
    sample_i  = s;
    fault_i   = f;
    irq_ack_i = ack;
    clear_i   = clr;
    @(posedge clk);
    #1;
    sample_i  = 1'b0;
    fault_i   = 3'b000;
    irq_ack_i = 1'b0;
    clear_i   = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic irq, input logic [2:0] syn,
                           input logic [7:0] cnt, input logic per, input logic [2:0] psrc);
    check({tag, ".irq"}, 32'(irq_o), 32'(irq));
    check({tag, ".syn"}, 32'(syndrome_o), 32'(syn));
    check({tag, ".cnt"}, 32'(total_cnt_o), 32'(cnt));
    check({tag, ".persist"}, 32'(persist_o), 32'(per));
    check({tag, ".psrc"}, 32'(persist_src_o), 32'(psrc));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    sample_i  = 1'b0;
    fault_i   = 3'b000;
    irq_ack_i = 1'b0;
    clear_i   = 1'b0;

    //            s     f       ack   clr   irq   syn     cnt
    tbl[0] = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 3'b010, 8'd1};
    tbl[1] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 3'b110, 8'd2};
    tbl[2] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b110, 8'd2};
    tbl[3] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b110, 8'd2};
    tbl[4] = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 3'b001, 8'd3};
    tbl[5] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 3'b001, 8'd4};
    tbl[6] = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 3'b100, 8'd5};
    tbl[7] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b100, 8'd5};
    tbl[8] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 8'd5};
    tbl[9] = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b000, 8'd0};

    #12;
    check_all("reset", 1'b0, 3'b000, 8'd0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].f, tbl[i].ack, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].irq, tbl[i].syn, tbl[i].cnt, 1'b0, 3'b000);
    end

    // Four gapped faults on source 0 lock (when enabled); ack is then ignored.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'b001, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 1'b0);
    end
    check_all("lock4", 1'b1, 3'b001, 8'd4, PEN, PEN ? 3'b001 : 3'b000);
    step(1'b0, 3'b000, 1'b1, 1'b0);
    check_all("lock_ack", PEN, 3'b001, 8'd4, PEN, PEN ? 3'b001 : 3'b000);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    check_all("lock_or", 1'b1, PEN ? 3'b101 : 3'b100, 8'd5, PEN, PEN ? 3'b001 : 3'b000);

    // Clean sample after three faults restarts the run: no lock.
    step(1'b0, 3'b000, 1'b0, 1'b1);
    check_all("clr1", 1'b0, 3'b000, 8'd0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    check_all("nolock", 1'b1, 3'b010, 8'd6, 1'b0, 3'b000);
    step(1'b0, 3'b000, 1'b1, 1'b0);
    check_all("nolock_ack", 1'b0, 3'b010, 8'd6, 1'b0, 3'b000);

    // Counter saturation, then clear beats a simultaneous event.
    step(1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 3'((i % 7) + 1), 1'b0, 1'b0);
      if (i == 253) check("cnt254", 32'(total_cnt_o), 32'd254);
    end
    check("cnt_sat", 32'(total_cnt_o), 32'd255);
    check("sat_irq", 32'(irq_o), 32'd1);
    step(1'b1, 3'b111, 1'b0, 1'b1);
    check_all("clr_sat", 1'b0, 3'b000, 8'd0, 1'b0, 3'b000);

    // Async reset mid-alarm/lock clears outputs before the next edge.
    for (int i = 0; i < 4; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
    check_all("pre_rst", 1'b1, 3'b010, 8'd4, PEN, PEN ? 3'b010 : 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 3'b000, 8'd0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b010, 1'b0, 1'b0);
    check_all("post_rst", 1'b1, 3'b010, 8'd1, 1'b0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
